rgb_pwm_sequencer: RTL and testbench

Parametrised multi-channel LED PWM engine that replaces the fixed divider-plus-counter LED drive in board tops. Each channel has its own mode (off, static duty, breathe, blink) and its own level, set through a simple write port. Duty changes are glitch-free. The pwm outputs connect directly to the RGBxPWM inputs of SB_RGBA_DRV, with the colour mapping done by the per-board defines in the top.

---
 rtl/rgb_pwm_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: multi-channel LED PWM engine with per-channel OFF /
// STATIC / BREATHE / BLINK modes. Shadow configuration is written at any time;
// the duty actually driven is latched only at the end of a PWM period, so a
// period is never cut short or stretched by a configuration write.
// rst_n is asserted asynchronously; its release is expected to be synchronous
// to clk (provided by the board-level reset logic).
module rgb_pwm_sequencer #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 4,
  parameter int BLINK_BITS    = 5,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_strobe
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Saturating decrement used by the breathe ramp.
  function automatic logic [PWM_BITS-1:0] dec_sat(input logic [PWM_BITS-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // One breathe step: returns {dir, fade} for the next period.
  // fade never exceeds the ceiling on the way up, so the increment cannot wrap.
  function automatic logic [PWM_BITS:0] breathe_step(
    input logic                dir,
    input logic [PWM_BITS-1:0] fade,
    input logic [PWM_BITS-1:0] level
  );
    logic                nd;
    logic [PWM_BITS-1:0] nf;
    nd = dir;
    nf = fade;
    if (dir == DIR_UP) begin
      if (fade >= level) begin
        nd = DIR_DOWN;
        nf = dec_sat(fade);
      end else begin
        nf = fade + 1'b1;
      end
    end else begin
      if (fade == '0) begin
        nd = DIR_UP;
        nf = (level == '0) ? '0 : PWM_BITS'(1);
      end else begin
        nf = fade - 1'b1;
      end
    end
    return {nd, nf};
  endfunction

  logic                tick;
  logic                period_end;
  logic                cfg_ok;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                strobe_q;
  logic [CHANNELS-1:0] pwm_q;
  logic [CHANNELS-1:0] pwm_d;

  mode_e                 mode_q   [CHANNELS];
  mode_e                 mode_d   [CHANNELS];
  logic [PWM_BITS-1:0]   level_q  [CHANNELS];
  logic [PWM_BITS-1:0]   level_d  [CHANNELS];
  logic [PWM_BITS-1:0]   fade_q   [CHANNELS];
  logic [PWM_BITS-1:0]   fade_d   [CHANNELS];
  logic [PWM_BITS-1:0]   active_q [CHANNELS];
  logic [PWM_BITS-1:0]   active_d [CHANNELS];
  logic                  dir_q    [CHANNELS];
  logic                  dir_d    [CHANNELS];
  logic                  phase_q  [CHANNELS];
  logic                  phase_d  [CHANNELS];
  logic [BLINK_BITS-1:0] bcnt_q   [CHANNELS];
  logic [BLINK_BITS-1:0] bcnt_d   [CHANNELS];

  // Writes addressed beyond the last channel are dropped.
  assign cfg_ok = (int'(cfg_ch) < CHANNELS);

  // Prescaler: tick once every 2^PRESCALE_BITS enabled clocks.
  if (PRESCALE_BITS > 0) begin : g_presc
    logic [PRESCALE_BITS-1:0] presc_q;

    // Free-running prescaler, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
      end else if (!en) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end

    assign tick = en & (&presc_q);
  end else begin : g_nopresc
    assign tick = en;
  end

  assign period_end = tick & (&pwm_cnt_q);

  // PWM period counter and end-of-period strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else if (!en) begin
      pwm_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
      strobe_q <= period_end;
    end
  end

  // Per-channel next state: duty latch and mode stepping at period end, then
  // configuration writes. A mode-changing write restarts the channel's
  // breathe/blink state and takes priority over the period-end step.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      level_d[i]  = level_q[i];
      fade_d[i]   = fade_q[i];
      active_d[i] = active_q[i];
      dir_d[i]    = dir_q[i];
      phase_d[i]  = phase_q[i];
      bcnt_d[i]   = bcnt_q[i];
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (period_end) begin
        case (mode_q[i])
          MODE_OFF: begin
            active_d[i] = '0;
          end
          MODE_STATIC: begin
            active_d[i] = level_q[i];
          end
          MODE_BREATHE: begin
            active_d[i]            = fade_q[i];
            {dir_d[i], fade_d[i]}  = breathe_step(dir_q[i], fade_q[i], level_q[i]);
          end
          MODE_BLINK: begin
            active_d[i] = phase_q[i] ? level_q[i] : '0;
            bcnt_d[i]   = bcnt_q[i] + 1'b1;
            if (&bcnt_q[i]) begin
              phase_d[i] = ~phase_q[i];
            end
          end
          default: begin
            active_d[i] = '0;
          end
        endcase
      end

      if (cfg_we && cfg_ok && (int'(cfg_ch) == i)) begin
        mode_d[i]  = mode_e'(cfg_mode);
        level_d[i] = cfg_level;
        if (mode_e'(cfg_mode) != mode_q[i]) begin
          fade_d[i]  = '0;
          dir_d[i]   = DIR_UP;
          bcnt_d[i]  = '0;
          phase_d[i] = 1'b1;
        end
      end
    end
  end

  // Output compare against the duty latched for the current period.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en & (pwm_cnt_q < active_q[i]);
    end
  end

  // Per-channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        level_q[i]  <= '0;
        fade_q[i]   <= '0;
        active_q[i] <= '0;
        dir_q[i]    <= DIR_UP;
        phase_q[i]  <= 1'b1;
        bcnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        level_q[i]  <= level_d[i];
        fade_q[i]   <= fade_d[i];
        active_q[i] <= active_d[i];
        dir_q[i]    <= dir_d[i];
        phase_q[i]  <= phase_d[i];
        bcnt_q[i]   <= bcnt_d[i];
      end
    end
  end

  // Registered PWM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm           = pwm_q;
  assign period_strobe = strobe_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with PWM_BITS=4, PRESCALE_BITS=1,
// BLINK_BITS=1, CHANNELS=3 (32-clk period). High times are counted in clks.
module tb_rgb_pwm_sequencer;

  localparam logic [1:0] M_OFF = 2'd0, M_STATIC = 2'd1, M_BREATHE = 2'd2, M_BLINK = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_level = 4'd0;
  logic [2:0] pwm;
  logic       period_strobe;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_pwm_sequencer #(
    .CHANNELS(3),
    .PWM_BITS(4),
    .PRESCALE_BITS(1),
    .BLINK_BITS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_level(cfg_level),
    .pwm(pwm),
    .period_strobe(period_strobe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Single-cycle config write starting at the current negedge.
  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_level = lvl;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Advance to the next negedge where period_strobe is seen (bounded).
  task automatic sync_strobe(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_strobe && k < 100);
    check(tag, period_strobe, 1);
  endtask

  // Measure one period starting from a strobe negedge; optionally drive a write
  // at sample wr_at (1..31). Expected -1 skips that channel.
  task automatic period(input string tag, input int wr_at, input logic [1:0] wch,
                        input logic [1:0] wmode, input logic [3:0] wlvl,
                        input int e0, input int e1, input int e2);
    int h0, h1, h2, nstb, stb_at;
    h0 = 0; h1 = 0; h2 = 0; nstb = 0; stb_at = 0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      h2 += int'(pwm[2]);
      if (period_strobe) begin
        nstb++;
        stb_at = j;
      end
      if (j == wr_at) begin
        cfg_we = 1'b1; cfg_ch = wch; cfg_mode = wmode; cfg_level = wlvl;
      end else begin
        cfg_we = 1'b0;
      end
    end
    if (e0 >= 0) check({tag, "_ch0"}, h0, e0);
    if (e1 >= 0) check({tag, "_ch1"}, h1, e1);
    if (e2 >= 0) check({tag, "_ch2"}, h2, e2);
    check({tag, "_nstb"}, nstb, 1);
    check({tag, "_stbpos"}, stb_at, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int breathe_exp[10];
    int blink_exp[6];
    int hs, ss, first;
    breathe_exp = '{0, 2, 4, 6, 4, 2, 0, 2, 4, 6};
    blink_exp   = '{16, 16, 0, 0, 16, 16};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_stb", period_strobe, 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // Idle: no writes, outputs low, strobe every 32 clks
    sync_strobe("sync_idle");
    period("idle_a", 0, 2'd0, M_OFF, 4'd0, 0, 0, 0);
    period("idle_b", 0, 2'd0, M_OFF, 4'd0, 0, 0, 0);

    // STATIC levels on ch0
    cfg_write(2'd0, M_STATIC, 4'd4);
    sync_strobe("sync_st4");
    period("st4", 0, 2'd0, M_OFF, 4'd0, 8, 0, 0);
    cfg_write(2'd0, M_STATIC, 4'd0);
    sync_strobe("sync_st0");
    period("st0", 0, 2'd0, M_OFF, 4'd0, 0, 0, 0);
    cfg_write(2'd0, M_STATIC, 4'd15);
    sync_strobe("sync_st15");
    period("st15", 0, 2'd0, M_OFF, 4'd0, 30, 0, 0);

    // Mid-period write and write on the period_end clk (ch1)
    cfg_write(2'd1, M_STATIC, 4'd4);
    sync_strobe("sync_mid");
    period("mid_cur", 10, 2'd1, M_STATIC, 4'd12, 30, 8, 0);
    period("mid_next", 0, 2'd0, M_OFF, 4'd0, 30, 24, 0);
    period("same_cur", 31, 2'd1, M_STATIC, 4'd4, 30, 24, 0);
    period("same_p1", 0, 2'd0, M_OFF, 4'd0, 30, 24, 0);
    period("same_p2", 0, 2'd0, M_OFF, 4'd0, 30, 8, 0);

    // BREATHE level 3 on ch2: 0,1,2,3,2,1,0,1,2,3 ticks
    cfg_write(2'd2, M_BREATHE, 4'd3);
    sync_strobe("sync_br");
    for (int k = 0; k < 10; k++) begin
      period($sformatf("breathe%0d", k), 0, 2'd0, M_OFF, 4'd0, 30, 8, breathe_exp[k]);
    end

    // BLINK level 8 on ch0: 8,8,0,0,8,8 ticks
    cfg_write(2'd0, M_BLINK, 4'd8);
    sync_strobe("sync_blk");
    for (int k = 0; k < 6; k++) begin
      period($sformatf("blink%0d", k), 0, 2'd0, M_OFF, 4'd0, blink_exp[k], 8, -1);
    end
    // Same-mode rewrite keeps phase (currently off, one more off period)
    period("blk_rw", 1, 2'd0, M_BLINK, 4'd10, 0, 8, -1);
    period("blk_p8", 0, 2'd0, M_OFF, 4'd0, 0, 8, -1);
    period("blk_p9", 0, 2'd0, M_OFF, 4'd0, 20, 8, -1);
    period("blk_p10", 0, 2'd0, M_OFF, 4'd0, 20, 8, -1);
    // STATIC then BLINK restarts the blink in phase on
    period("blk_p11", 2, 2'd0, M_STATIC, 4'd10, 0, 8, -1);
    period("blk_p12", 2, 2'd0, M_BLINK, 4'd10, 20, 8, -1);
    period("blk_p13", 0, 2'd0, M_OFF, 4'd0, 20, 8, -1);
    period("blk_p14", 0, 2'd0, M_OFF, 4'd0, 20, 8, -1);
    period("blk_p15", 0, 2'd0, M_OFF, 4'd0, 0, 8, -1);

    // Out-of-range channel write is ignored
    cfg_write(2'd0, M_STATIC, 4'd6);
    cfg_write(2'd1, M_STATIC, 4'd4);
    cfg_write(2'd2, M_STATIC, 4'd2);
    sync_strobe("sync_set");
    period("set", 0, 2'd0, M_OFF, 4'd0, 12, 8, 4);
    period("badch", 5, 2'd3, M_BLINK, 4'd15, 12, 8, 4);
    period("badch_after", 0, 2'd0, M_OFF, 4'd0, 12, 8, 4);

    // Asynchronous reset between clock edges
    @(negedge clk);
    check("pre_rst_pwm", pwm, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_stb", period_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync_strobe("sync_post_rst");
    period("post_rst", 0, 2'd0, M_OFF, 4'd0, 0, 0, 0);

    // Global enable off and back on
    cfg_write(2'd0, M_STATIC, 4'd4);
    sync_strobe("sync_en");
    period("en_pre", 0, 2'd0, M_OFF, 4'd0, 8, 0, 0);
    en = 1'b0;
    hs = 0; ss = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      hs += int'(pwm[0]) + int'(pwm[1]) + int'(pwm[2]);
      ss += int'(period_strobe);
    end
    check("en_off_pwm", hs, 0);
    check("en_off_stb", ss, 0);
    en = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (period_strobe) begin
        first = k;
        break;
      end
    end
    check("en_first_stb", first, 32);
    period("en_post", 0, 2'd0, M_OFF, 4'd0, 8, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
